host_pkt_arb: RTL and testbench

Packet-atomic arbiter that shares the single 8-bit host transport byte stream (the dual-clock TX/RX FIFO pair in front of the UART) between three on-chip clients: ch0 host master, ch1 host slave, ch2 event/IRQ channel. On TX it round-robins between clients and forwards one complete packet at a time, stamping the channel id into the header. On RX it decodes each header and steers the whole packet to the addressed client, or discards it. It sits between the client byte FIFOs and the transport FIFOs in the CLK domain.

---
 rtl/host_pkt_arb.sv | 198 +++++++++++++++++++
 tb/tb_host_pkt_arb.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_pkt_arb.sv
// Packet-atomic arbiter between three client byte FIFOs and the shared host transport FIFOs.
// TX round-robins whole packets and stamps the channel id; RX steers each packet by its header.
module host_pkt_arb #(
  parameter int DROP_W = 8
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [2:0]        ch_en,
  input  logic [2:0]        tx_empty,
  input  logic [23:0]       tx_data,
  output logic [2:0]        tx_rd,
  output logic              com_wren,
  output logic [7:0]        com_wrdata,
  input  logic              com_wrfull,
  input  logic              com_rdempty,
  input  logic [7:0]        com_rddata,
  output logic              com_rden,
  output logic [2:0]        rx_wr,
  output logic [7:0]        rx_data,
  input  logic [2:0]        rx_full,
  output logic [1:0]        tx_owner,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {T_IDLE, T_HDR, T_BODY} tx_state_e;
  typedef enum logic [1:0] {R_HDR, R_BODY, R_DROP} rx_state_e;

  tx_state_e   tx_state_q;
  logic [1:0]  own_q;
  logic [1:0]  last_grant_q;
  logic [1:0]  tx_owner_q;
  logic [5:0]  tx_cnt_q;

  rx_state_e   rx_state_q;
  logic [1:0]  dest_q;
  logic [5:0]  rx_cnt_q;
  logic [DROP_W-1:0] drop_cnt_q;

  logic [2:0]  tx_req;
  logic [1:0]  grant_d;
  logic        grant_vld_d;
  logic [7:0]  own_byte;
  logic        own_empty;
  logic        tx_xfer;

  logic [1:0]  hdr_dest;
  logic [3:0]  en_ext;
  logic [3:0]  full_ext;
  logic        hdr_drop;
  logic [1:0]  wr_dest;
  logic        rx_deliver;
  logic        drop_pop;

  function automatic logic [1:0] rr_idx(input logic [1:0] last, input int k);
    return 2'((int'(last) + 1 + k) % 3);
  endfunction

  // ---------------- TX path ----------------
  assign tx_req = ch_en & ~tx_empty;

  // Descending scan so the candidate closest to last_grant+1 is written last and wins.
  always_comb begin
    grant_d     = 2'd0;
    grant_vld_d = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      if (tx_req[rr_idx(last_grant_q, k)]) begin
        grant_d     = rr_idx(last_grant_q, k);
        grant_vld_d = 1'b1;
      end
    end
  end

  always_comb begin
    own_byte  = 8'h00;
    own_empty = 1'b1;
    case (own_q)
      2'd0:    begin own_byte = tx_data[7:0];   own_empty = tx_empty[0]; end
      2'd1:    begin own_byte = tx_data[15:8];  own_empty = tx_empty[1]; end
      2'd2:    begin own_byte = tx_data[23:16]; own_empty = tx_empty[2]; end
      default: begin own_byte = 8'h00;          own_empty = 1'b1;        end
    endcase
  end

  assign tx_xfer    = RESETn && (tx_state_q != T_IDLE) && !own_empty && !com_wrfull;
  assign com_wren   = tx_xfer;
  assign tx_rd      = tx_xfer ? (3'b001 << own_q) : 3'b000;
  assign com_wrdata = (tx_state_q == T_HDR) ? {own_q, own_byte[5:0]} : own_byte;
  assign tx_owner   = tx_owner_q;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      tx_state_q   <= T_IDLE;
      own_q        <= 2'd0;
      last_grant_q <= 2'd2;
      tx_owner_q   <= 2'd3;
      tx_cnt_q     <= 6'd0;
    end else begin
      case (tx_state_q)
        T_IDLE: begin
          if (grant_vld_d) begin
            own_q      <= grant_d;
            tx_owner_q <= grant_d;
            tx_state_q <= T_HDR;
          end
        end
        T_HDR: begin
          if (tx_xfer) begin
            tx_cnt_q <= own_byte[5:0];
            if (own_byte[5:0] == 6'd0) begin
              // Empty packet is complete: rotate priority so a stream of them cannot starve peers.
              tx_state_q   <= T_IDLE;
              tx_owner_q   <= 2'd3;
              last_grant_q <= own_q;
            end else begin
              tx_state_q <= T_BODY;
            end
          end
        end
        T_BODY: begin
          if (tx_xfer) begin
            tx_cnt_q <= tx_cnt_q - 6'd1;
            if (tx_cnt_q == 6'd1) begin
              tx_state_q   <= T_IDLE;
              tx_owner_q   <= 2'd3;
              last_grant_q <= own_q;
            end
          end
        end
        default: tx_state_q <= T_IDLE;
      endcase
    end
  end

  // ---------------- RX path ----------------
  assign hdr_dest = com_rddata[7:6];
  assign en_ext   = {1'b0, ch_en};
  assign full_ext = {1'b1, rx_full};
  assign hdr_drop = !en_ext[hdr_dest];
  assign wr_dest  = (rx_state_q == R_HDR) ? hdr_dest : dest_q;

  always_comb begin
    rx_deliver = 1'b0;
    drop_pop   = 1'b0;
    if (RESETn && !com_rdempty) begin
      case (rx_state_q)
        R_HDR: begin
          if (hdr_drop)                   drop_pop   = 1'b1;
          else if (!full_ext[hdr_dest])   rx_deliver = 1'b1;
        end
        R_BODY:  rx_deliver = !full_ext[dest_q];
        R_DROP:  drop_pop   = 1'b1;
        default: ;
      endcase
    end
  end

  assign rx_wr    = rx_deliver ? (3'b001 << wr_dest) : 3'b000;
  assign com_rden = rx_deliver | drop_pop;
  assign rx_data  = com_rddata;
  assign drop_cnt = drop_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      rx_state_q <= R_HDR;
      dest_q     <= 2'd0;
      rx_cnt_q   <= 6'd0;
      drop_cnt_q <= '0;
    end else begin
      case (rx_state_q)
        R_HDR: begin
          if (drop_pop) begin
            rx_cnt_q <= com_rddata[5:0];
            if (drop_cnt_q != {DROP_W{1'b1}}) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
            if (com_rddata[5:0] != 6'd0) rx_state_q <= R_DROP;
          end else if (rx_deliver) begin
            dest_q   <= hdr_dest;
            rx_cnt_q <= com_rddata[5:0];
            if (com_rddata[5:0] != 6'd0) rx_state_q <= R_BODY;
          end
        end
        R_BODY: begin
          if (rx_deliver) begin
            rx_cnt_q <= rx_cnt_q - 6'd1;
            if (rx_cnt_q == 6'd1) rx_state_q <= R_HDR;
          end
        end
        R_DROP: begin
          if (drop_pop) begin
            rx_cnt_q <= rx_cnt_q - 6'd1;
            if (rx_cnt_q == 6'd1) rx_state_q <= R_HDR;
          end
        end
        default: rx_state_q <= R_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_host_pkt_arb.sv
// Scoreboard bench for host_pkt_arb: client/transport FIFOs are modelled as queues,
// expected com/rx bytes are queued at stimulus time and checked by a negedge monitor.
module tb_host_pkt_arb;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic [2:0]  ch_en = 3'b111;
  logic [2:0]  tx_empty = 3'b111;
  logic [23:0] tx_data = 24'h0;
  logic        com_wrfull = 1'b0;
  logic        com_rdempty = 1'b1;
  logic [7:0]  com_rddata = 8'h0;
  logic [2:0]  rx_full = 3'b000;

  wire [2:0] tx_rd;
  wire       com_wren;
  wire [7:0] com_wrdata;
  wire       com_rden;
  wire [2:0] rx_wr;
  wire [7:0] rx_data;
  wire [1:0] tx_owner;
  wire [7:0] drop_cnt;

  wire [2:0] tx_rd_2;
  wire       com_wren_2;
  wire [7:0] com_wrdata_2;
  wire       com_rden_2;
  wire [2:0] rx_wr_2;
  wire [7:0] rx_data_2;
  wire [1:0] tx_owner_2;
  wire [1:0] drop_cnt_2;

  always #5 CLK = ~CLK;

  host_pkt_arb #(.DROP_W(8)) dut (
    .CLK(CLK), .RESETn(RESETn), .ch_en(ch_en), .tx_empty(tx_empty), .tx_data(tx_data),
    .tx_rd(tx_rd), .com_wren(com_wren), .com_wrdata(com_wrdata), .com_wrfull(com_wrfull),
    .com_rdempty(com_rdempty), .com_rddata(com_rddata), .com_rden(com_rden),
    .rx_wr(rx_wr), .rx_data(rx_data), .rx_full(rx_full), .tx_owner(tx_owner), .drop_cnt(drop_cnt)
  );

  // Narrow-counter twin fed the same stream; only its saturating drop counter is observed.
  host_pkt_arb #(.DROP_W(2)) dut2 (
    .CLK(CLK), .RESETn(RESETn), .ch_en(ch_en), .tx_empty(tx_empty), .tx_data(tx_data),
    .tx_rd(tx_rd_2), .com_wren(com_wren_2), .com_wrdata(com_wrdata_2), .com_wrfull(com_wrfull),
    .com_rdempty(com_rdempty), .com_rddata(com_rddata), .com_rden(com_rden_2),
    .rx_wr(rx_wr_2), .rx_data(rx_data_2), .rx_full(rx_full), .tx_owner(tx_owner_2), .drop_cnt(drop_cnt_2)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] txq0[$];
  logic [7:0] txq1[$];
  logic [7:0] txq2[$];
  logic [7:0] rxq[$];
  logic [7:0] com_exp[$];
  logic [9:0] rx_exp[$];
  int         own_log[$];
  int         com_cyc[$];

  logic [2:0] tx_rd_s = 3'b000;
  logic       com_rden_s = 1'b0;
  int         cyc = 0;
  int         prev_owner = 3;
  int         rx_pop_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pending();
    return txq0.size() + txq1.size() + txq2.size() + rxq.size() + com_exp.size() + rx_exp.size();
  endfunction

  // FIFO models: apply the pops seen at the previous negedge, then present new heads.
  always @(posedge CLK) begin
    #1;
    if (tx_rd_s[0] && txq0.size() > 0) void'(txq0.pop_front());
    if (tx_rd_s[1] && txq1.size() > 0) void'(txq1.pop_front());
    if (tx_rd_s[2] && txq2.size() > 0) void'(txq2.pop_front());
    if (com_rden_s && rxq.size() > 0) void'(rxq.pop_front());
    tx_empty       = {txq2.size() == 0, txq1.size() == 0, txq0.size() == 0};
    tx_data[7:0]   = (txq0.size() > 0) ? txq0[0] : 8'h00;
    tx_data[15:8]  = (txq1.size() > 0) ? txq1[0] : 8'h00;
    tx_data[23:16] = (txq2.size() > 0) ? txq2[0] : 8'h00;
    com_rdempty    = (rxq.size() == 0);
    com_rddata     = (rxq.size() > 0) ? rxq[0] : 8'h00;
  end

  // Monitor: samples strobes mid-cycle and checks against the scoreboard queues.
  always @(negedge CLK) begin
    logic [2:0] exp_rd;
    logic [1:0] ch;
    cyc++;
    tx_rd_s    = tx_rd;
    com_rden_s = com_rden;
    if (RESETn && int'(tx_owner) != prev_owner && tx_owner != 2'd3) own_log.push_back(int'(tx_owner));
    prev_owner = int'(tx_owner);
    exp_rd = com_wren ? (3'b001 << tx_owner) : 3'b000;
    check("tx_rd_vs_owner", {29'd0, tx_rd}, {29'd0, exp_rd});
    if (com_wren) begin
      com_cyc.push_back(cyc);
      if (com_exp.size() == 0) begin
        checks++; errors++;
        $display("FAIL com_unexpected: got 0x%02h expected no write", com_wrdata);
      end else begin
        $display("com  byte 0x%02h owner %0d cycle %0d", com_wrdata, tx_owner, cyc);
        check("com_byte", {24'd0, com_wrdata}, {24'd0, com_exp.pop_front()});
      end
    end
    if (rx_wr != 3'b000) begin
      case (rx_wr)
        3'b001:  ch = 2'd0;
        3'b010:  ch = 2'd1;
        3'b100:  ch = 2'd2;
        default: ch = 2'd3;
      endcase
      if (rx_exp.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_unexpected: got ch%0d 0x%02h expected no write", ch, rx_data);
      end else begin
        $display("rx   byte 0x%02h to ch%0d cycle %0d", rx_data, ch, cyc);
        check("rx_byte", {22'd0, ch, rx_data}, {22'd0, rx_exp.pop_front()});
      end
    end
    if (com_rden) rx_pop_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while (pending() != 0 && n < max_cyc) begin
      step(1);
      n++;
    end
    check(name, pending(), 0);
    step(3);
  endtask

  task automatic check_strobes_idle(input string tag);
    check({tag, "_com_wren"}, {31'd0, com_wren}, 0);
    check({tag, "_com_rden"}, {31'd0, com_rden}, 0);
    check({tag, "_rx_wr"},    {29'd0, rx_wr}, 0);
    check({tag, "_tx_rd"},    {29'd0, tx_rd}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    RESETn = 1'b0; ch_en = 3'b111; rx_full = 3'b000; com_wrfull = 1'b0;
    step(3);
    check("rst_tx_owner", {30'd0, tx_owner}, 3);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 0);
    check_strobes_idle("rst");
    RESETn = 1'b1;
    step(2);

    // TX round-robin: ch0 first after reset, then ch2 with id stamped, one idle cycle between
    own_log.delete(); com_cyc.delete();
    txq0.push_back(8'h02); txq0.push_back(8'hAA); txq0.push_back(8'hBB);
    txq2.push_back(8'h02); txq2.push_back(8'hAA); txq2.push_back(8'hBB);
    com_exp.push_back(8'h02); com_exp.push_back(8'hAA); com_exp.push_back(8'hBB);
    com_exp.push_back(8'h82); com_exp.push_back(8'hAA); com_exp.push_back(8'hBB);
    wait_drain("rr_drain", 100);
    check("rr_owner_count", own_log.size(), 2);
    if (own_log.size() == 2) begin
      check("rr_owner_first", own_log[0], 0);
      check("rr_owner_second", own_log[1], 2);
    end
    if (com_cyc.size() == 6) begin
      check("rr_pkt0_contig", com_cyc[2] - com_cyc[0], 2);
      check("rr_idle_gap", com_cyc[3] - com_cyc[2], 2);
      check("rr_pkt1_contig", com_cyc[5] - com_cyc[3], 2);
    end else check("rr_com_count", com_cyc.size(), 6);
    check("rr_owner_none", {30'd0, tx_owner}, 3);

    // TX stall: ch1 goes empty mid-packet, ch0 must wait for it
    own_log.delete();
    com_exp.push_back(8'h43); com_exp.push_back(8'h10); com_exp.push_back(8'h11);
    com_exp.push_back(8'h12); com_exp.push_back(8'h01); com_exp.push_back(8'h77);
    txq1.push_back(8'h03); txq1.push_back(8'h10);
    step(2);
    txq0.push_back(8'h01); txq0.push_back(8'h77);
    step(5);
    check("stall_owner_held", {30'd0, tx_owner}, 1);
    check("stall_com_left", com_exp.size(), 4);
    txq1.push_back(8'h11); txq1.push_back(8'h12);
    wait_drain("stall_drain", 100);
    check("stall_owner_count", own_log.size(), 2);
    if (own_log.size() == 2) begin
      check("stall_owner_first", own_log[0], 1);
      check("stall_owner_second", own_log[1], 0);
    end

    // RX steer
    rxq.push_back(8'h41); rxq.push_back(8'h55); rxq.push_back(8'h00);
    rx_exp.push_back({2'd1, 8'h41}); rx_exp.push_back({2'd1, 8'h55}); rx_exp.push_back({2'd0, 8'h00});
    wait_drain("steer_drain", 100);

    // RX backpressure on ch2
    rx_full = 3'b100;
    rxq.push_back(8'h82); rxq.push_back(8'h11); rxq.push_back(8'h22);
    rx_exp.push_back({2'd2, 8'h82}); rx_exp.push_back({2'd2, 8'h11}); rx_exp.push_back({2'd2, 8'h22});
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("bp_no_rden", {31'd0, com_rden}, 0);
    end
    check("bp_held_bytes", rxq.size(), 3);
    rx_full = 3'b000;
    wait_drain("bp_drain", 100);

    // RX drop: dest 3, then disabled ch0
    ch_en = 3'b110;
    rx_pop_cnt = 0;
    rxq.push_back(8'hC3); rxq.push_back(8'h01); rxq.push_back(8'h02); rxq.push_back(8'h03);
    rxq.push_back(8'h05);
    for (int i = 0; i < 5; i++) rxq.push_back(8'hA0 + 8'(i));
    wait_drain("drop_drain", 100);
    check("drop_pops", rx_pop_cnt, 10);
    check("drop_cnt_2", {24'd0, drop_cnt}, 2);
    check("drop_cnt_narrow_2", {30'd0, drop_cnt_2}, 2);
    // Three more drops, including zero-length headers
    rxq.push_back(8'hC0); rxq.push_back(8'hC0); rxq.push_back(8'h01); rxq.push_back(8'h99);
    wait_drain("drop2_drain", 100);
    check("drop_pops_total", rx_pop_cnt, 14);
    check("drop_cnt_5", {24'd0, drop_cnt}, 5);
    check("drop_cnt_narrow_sat", {30'd0, drop_cnt_2}, 3);

    // Reset mid-packet: TX stuck in body, RX stuck in body
    ch_en = 3'b111;
    rxq.push_back(8'hC0); rxq.push_back(8'h43); rxq.push_back(8'h66);
    rx_exp.push_back({2'd1, 8'h43}); rx_exp.push_back({2'd1, 8'h66});
    txq0.push_back(8'h05); txq0.push_back(8'h31); txq0.push_back(8'h32);
    com_exp.push_back(8'h05); com_exp.push_back(8'h31); com_exp.push_back(8'h32);
    wait_drain("mid_drain", 100);
    check("mid_owner", {30'd0, tx_owner}, 0);
    check("mid_drop_cnt", {24'd0, drop_cnt}, 6);
    RESETn = 1'b0;
    step(1);
    check("mrst_tx_owner", {30'd0, tx_owner}, 3);
    check("mrst_drop_cnt", {24'd0, drop_cnt}, 0);
    check_strobes_idle("mrst");
    txq1.push_back(8'h00); txq0.push_back(8'h00); rxq.push_back(8'h00);
    step(2);
    check_strobes_idle("mrst_pending");
    own_log.delete();
    com_exp.push_back(8'h00); com_exp.push_back(8'h40);
    rx_exp.push_back({2'd0, 8'h00});
    RESETn = 1'b1;
    wait_drain("post_rst_drain", 100);
    check("post_rst_owner_count", own_log.size(), 2);
    if (own_log.size() == 2) begin
      check("post_rst_first", own_log[0], 0);
      check("post_rst_second", own_log[1], 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
